// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU share arbiter: opcode constants
// and FSM state encoding.
package alu_arb_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters, the response consumer
// (master side) and the ALU share arbiter (slave side).
interface alu_share_arbiter_if #(
   parameter int DATA_W = 4
);
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [1:0]        req0_op;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [1:0]        req1_op;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_res;
   logic              rsp_cout;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_res, rsp_cout,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_res, rsp_cout,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_share_arbiter_alu_core.sv
// Purely combinational 4-operation ALU; cout is the carry for ADD and the
// no-borrow flag for SUB, zero for the logic operations.
module alu_core
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [1:0]        op_i,
   output logic [DATA_W-1:0] res_o,
   output logic              cout_o
);

   localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

   logic [DATA_W:0] sum;

   // Subtraction is done as a + ~b + 1 so the top bit is the no-borrow flag.
   always_comb begin
      sum    = '0;
      res_o  = '0;
      cout_o = 1'b0;
      case (op_i)
         OP_ADD: begin
            sum    = {1'b0, a_i} + {1'b0, b_i};
            res_o  = sum[DATA_W-1:0];
            cout_o = sum[DATA_W];
         end
         OP_SUB: begin
            sum    = {1'b0, a_i} + {1'b0, ~b_i} + ONE;
            res_o  = sum[DATA_W-1:0];
            cout_o = sum[DATA_W];
         end
         OP_AND: res_o = a_i & b_i;
         default: res_o = a_i | b_i;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters; IDLE/EXEC/RESP FSM.
// Define ALU_ARB_STATS_EN to build the saturating per-requester grant counters.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   alu_share_arbiter_if.slave bus,
   output logic              busy,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
);

   arb_state_t        state_q, state_d;
   logic              last_grant_q;
   logic [DATA_W-1:0] opa_q, opb_q;
   logic [1:0]        opc_q;
   logic              opid_q;
   logic              rsp_valid_q, rsp_id_q, rsp_cout_q;
   logic [DATA_W-1:0] rsp_res_q;

   logic              pick0, pick1;
   logic              accept0, accept1, accept;
   logic [DATA_W-1:0] alu_res;
   logic              alu_cout;

   // On a tie the requester that did not win last time gets the ALU.
   always_comb begin
      pick0 = 1'b0;
      pick1 = 1'b0;
      if (ena) begin
         if (bus.req0_valid && (!bus.req1_valid || last_grant_q))
            pick0 = 1'b1;
         else if (bus.req1_valid)
            pick1 = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept0        = (state_q == IDLE) && pick0;
      accept1        = (state_q == IDLE) && pick1;
      accept         = accept0 || accept1;
      bus.req0_ready = accept0;
      bus.req1_ready = accept1;
      busy           = (state_q != IDLE);
   end

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .a_i    (opa_q),
      .b_i    (opb_q),
      .op_i   (opc_q),
      .res_o  (alu_res),
      .cout_o (alu_cout)
   );

   // Operands are sampled only on the grant cycle; the response is latched in EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         opa_q        <= '0;
         opb_q        <= '0;
         opc_q        <= OP_ADD;
         opid_q       <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_res_q    <= '0;
         rsp_cout_q   <= 1'b0;
      end else begin
         if (accept) begin
            last_grant_q <= accept1;
            opid_q       <= accept1;
            opa_q        <= accept1 ? bus.req1_a  : bus.req0_a;
            opb_q        <= accept1 ? bus.req1_b  : bus.req0_b;
            opc_q        <= accept1 ? bus.req1_op : bus.req0_op;
         end
         if (state_q == EXEC) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= opid_q;
            rsp_res_q   <= alu_res;
            rsp_cout_q  <= alu_cout;
         end else if (state_q == RESP && rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_res   = rsp_res_q;
   assign bus.rsp_cout  = rsp_cout_q;

`ifdef ALU_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (accept0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_ONE;
         if (accept1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_ONE;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`else
   assign grant_cnt0 = '0;
   assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter: ALU results, round-robin
// order, response back-pressure, mid-operation reset and grant statistics.
module tb_alu_share_arbiter;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       busy;
   logic [7:0] grant_cnt0, grant_cnt1;

   int compareCount;
   int mismatchCount;

   alu_share_arbiter_if #(.DATA_W(4)) bus ();

   alu_share_arbiter #(.DATA_W(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .bus        (bus),
      .busy       (busy),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop so a stuck design cannot hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic v1,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [1:0] op);
      bus.req0_valid = v0;
      bus.req1_valid = v1;
      bus.req0_a     = a;
      bus.req0_b     = b;
      bus.req0_op    = op;
      bus.req1_a     = a;
      bus.req1_b     = b;
      bus.req1_op    = op;
   endtask

   task automatic resetDut();
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
      bus.rsp_ready = 1'b1;
      ena           = 1'b1;
      rst_n         = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
      checkOutput("rst_rsp_res", bus.rsp_res, 4'h0);
      checkOutput("rst_rsp_id", bus.rsp_id, 1'b0);
      checkOutput("rst_ready0", bus.req0_ready, 1'b0);
      rst_n = 1'b1;
   endtask

   // One full transaction from a single requester with rsp_ready high.
   task automatic runOp(input string tag, input logic id,
                        input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic [3:0] expRes, input logic expCout);
      @(negedge clk);
      applyStimulus(!id, id, a, b, op);
      #1;
      checkOutput({tag, "_ready_grant"}, id ? bus.req1_ready : bus.req0_ready, 1'b1);
      checkOutput({tag, "_ready_other"}, id ? bus.req0_ready : bus.req1_ready, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
      checkOutput({tag, "_exec_busy"}, busy, 1'b1);
      checkOutput({tag, "_exec_valid"}, bus.rsp_valid, 1'b0);
      @(negedge clk);
      checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
      checkOutput({tag, "_rsp_res"}, bus.rsp_res, expRes);
      checkOutput({tag, "_rsp_cout"}, bus.rsp_cout, expCout);
      checkOutput({tag, "_rsp_id"}, bus.rsp_id, id);
      @(negedge clk);
      checkOutput({tag, "_idle_busy"}, busy, 1'b0);
      checkOutput({tag, "_idle_valid"}, bus.rsp_valid, 1'b0);
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      rst_n         = 1'b0;
      ena           = 1'b1;
      bus.rsp_ready = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);

      resetDut();
      runOp("add_9_8", 1'b0, 4'd9, 4'd8, OP_ADD, 4'd1, 1'b1);
      runOp("sub_3_5", 1'b1, 4'd3, 4'd5, OP_SUB, 4'hE, 1'b0);
      runOp("sub_5_3", 1'b1, 4'd5, 4'd3, OP_SUB, 4'd2, 1'b1);
      runOp("and_c_a", 1'b0, 4'hC, 4'hA, OP_AND, 4'h8, 1'b0);
      runOp("or_a_5",  1'b1, 4'hA, 4'h5, OP_OR,  4'hF, 1'b0);
      runOp("add_f_1", 1'b0, 4'hF, 4'h1, OP_ADD, 4'h0, 1'b1);

      // Both requesters valid continuously: grants must alternate 0,1,0,1.
      resetDut();
      @(negedge clk);
      bus.req0_valid = 1'b1;
      bus.req0_a     = 4'd2;
      bus.req0_b     = 4'd3;
      bus.req0_op    = OP_ADD;
      bus.req1_valid = 1'b1;
      bus.req1_a     = 4'hA;
      bus.req1_b     = 4'h5;
      bus.req1_op    = OP_OR;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("rr_ready0", bus.req0_ready, (i % 2) == 0);
         checkOutput("rr_ready1", bus.req1_ready, (i % 2) == 1);
         @(negedge clk);
         checkOutput("rr_exec_ready0", bus.req0_ready, 1'b0);
         checkOutput("rr_exec_ready1", bus.req1_ready, 1'b0);
         @(negedge clk);
         checkOutput("rr_rsp_id", bus.rsp_id, (i % 2) == 1);
         checkOutput("rr_rsp_res", bus.rsp_res, ((i % 2) == 1) ? 4'hF : 4'h5);
         @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);

      // Response back-pressure for 5 cycles.
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 4'hC, 4'hA, OP_AND);
      #1;
      checkOutput("bp_ready1", bus.req1_ready, 1'b1);
      @(negedge clk);
      bus.req1_valid = 1'b0;
      bus.req0_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_valid", bus.rsp_valid, 1'b1);
         checkOutput("bp_res", bus.rsp_res, 4'h8);
         checkOutput("bp_id", bus.rsp_id, 1'b1);
         checkOutput("bp_ready0", bus.req0_ready, 1'b0);
         checkOutput("bp_ready1", bus.req1_ready, 1'b0);
         checkOutput("bp_busy", busy, 1'b1);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_busy", busy, 1'b0);
      checkOutput("bp_release_valid", bus.rsp_valid, 1'b0);
      checkOutput("bp_release_ready0", bus.req0_ready, 1'b1);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);

      // Reset pulse during EXEC drops the operation.
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 4'd9, 4'd2, OP_SUB);
      #1;
      checkOutput("mr_ready1", bus.req1_ready, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
      checkOutput("mr_exec_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("mr_busy", busy, 1'b0);
      checkOutput("mr_valid", bus.rsp_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("mr_valid_after", bus.rsp_valid, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd1, 4'd1, OP_ADD);
      #1;
      checkOutput("mr_tie_ready0", bus.req0_ready, 1'b1);
      checkOutput("mr_tie_ready1", bus.req1_ready, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
      @(negedge clk);
      checkOutput("mr_rsp_valid", bus.rsp_valid, 1'b1);
      checkOutput("mr_rsp_id", bus.rsp_id, 1'b0);
      checkOutput("mr_rsp_res", bus.rsp_res, 4'd2);
      @(negedge clk);

      // ena low in IDLE blocks grants.
      ena = 1'b0;
      applyStimulus(1'b1, 1'b0, 4'd1, 4'd1, OP_ADD);
      #1;
      checkOutput("ena_low_ready0", bus.req0_ready, 1'b0);
      @(negedge clk);
      checkOutput("ena_low_busy", busy, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
      ena = 1'b1;

      // Grant statistics: 3 accepts from req0, 2 from req1.
      resetDut();
      runOp("st0a", 1'b0, 4'd1, 4'd2, OP_ADD, 4'd3, 1'b0);
      runOp("st1a", 1'b1, 4'd7, 4'd7, OP_SUB, 4'd0, 1'b1);
      runOp("st0b", 1'b0, 4'd6, 4'd3, OP_OR,  4'd7, 1'b0);
      runOp("st1b", 1'b1, 4'd8, 4'd8, OP_ADD, 4'd0, 1'b1);
      runOp("st0c", 1'b0, 4'd6, 4'd3, OP_AND, 4'd2, 1'b0);
`ifdef ALU_ARB_STATS_EN
      checkOutput("grant_cnt0", grant_cnt0, 8'd3);
      checkOutput("grant_cnt1", grant_cnt1, 8'd2);
`else
      checkOutput("grant_cnt0", grant_cnt0, 8'd0);
      checkOutput("grant_cnt1", grant_cnt1, 8'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 4-bit ALU (ADD/SUB/AND/OR, 4-bit result plus carry) between two requesters. It sits between the pin-level decode in the Tiny Tapeout top and the ALU core. Each requester presents operands and an opcode on a valid/ready handshake. A round-robin arbiter grants the shared ALU, a three-state FSM sequences one operation at a time, and each result is returned on a registered response channel tagged with the requester id.

## Interface
- `DATA_W`, default 4: operand and result width.
- `CNT_W`, default 8: width of the grant statistics counters.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ena`, in, 1: when low, no new request is accepted; an in-flight operation still completes.
- `req0_valid`, in, 1: requester 0 has a pending operation.
- `req0_ready`, out, 1: requester 0 operation accepted this cycle.
- `req0_a`, in, DATA_W: requester 0 operand A.
- `req0_b`, in, DATA_W: requester 0 operand B.
- `req0_op`, in, 2: requester 0 opcode (00 ADD, 01 SUB, 10 AND, 11 OR).
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `rsp_valid`, out, 1: response holds a result.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_id`, out, 1: requester that issued the result.
- `rsp_res`, out, DATA_W: ALU result.
- `rsp_cout`, out, 1: carry / no-borrow flag.
- `busy`, out, 1: FSM is not in IDLE.
- `grant_cnt0`, `grant_cnt1`, out, CNT_W each: accepted-request counts (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If `ena` is high and any `reqN_valid` is high, grant one requester.
  - The grant drives that requester's `reqN_ready` high combinationally for the cycle.
  - Operands, opcode and id are captured into operand registers; `last_grant` updates to the granted id.
  - Next state is EXEC.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not `last_grant`.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- EXEC:
  - The ALU core evaluates the registered operands.
  - `rsp_res`, `rsp_cout` and `rsp_id` are registered and `rsp_valid` is set.
  - Next state is RESP.
- RESP:
  - `rsp_*` hold stable while `rsp_ready` is low.
  - On `rsp_valid && rsp_ready`, clear `rsp_valid` and go to IDLE. No accept occurs in the same cycle.
- ALU rules, all results modulo 2^DATA_W:
  - ADD: `res = a + b`; `cout` is the carry out.
  - SUB: `res = a - b`; `cout` is the carry of `a + ~b + 1`, so 1 when a >= b.
  - AND, OR: bitwise; `cout = 0`.
- `reqN_ready` is never high outside IDLE, and never high for both requesters in one cycle.
- `ena` falling while in EXEC or RESP: the operation finishes normally. `ena` low in IDLE blocks grants only.
- Reset asserted mid-operation: the in-flight operation is dropped and all state clears immediately.

## Timing
- Reset values:
  - FSM: IDLE.
  - `rsp_valid`, `rsp_id`, `rsp_res`, `rsp_cout`, `busy`: 0.
  - `reqN_ready`: 0.
  - Counters: 0.
  - `last_grant`: 1.
- Accept on edge N (ready && valid); `rsp_valid` rises after edge N+1.
- Latency is 2 cycles from accept to `rsp_valid`.
- Minimum issue interval is 3 cycles, with `rsp_ready` held high.
- Requesters must hold `reqN_*` stable while valid and not ready. The arbiter samples them only on the grant cycle.

## Configuration
- Macro `ALU_ARB_STATS_EN`.
- Defined: `grant_cnt0` and `grant_cnt1` increment on each accept from their requester and saturate at all-ones.
- Undefined: the counters are not built and both outputs are tied to 0.
- Arbitration and timing are identical in both builds.

## Structure
- Shared package `alu_arb_pkg` holds:
  - Opcode constants `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`.
  - The FSM state typedef with encodings IDLE=0, EXEC=1, RESP=2.
- Sub-module `alu_core` holds the purely combinational 4-op ALU (a, b, op -> res, cout). It is instantiated once and reused by the existing top.

## Test plan
- After reset, req0 ADD a=9 b=8 with `rsp_ready`=1: `req0_ready` on the first cycle; 2 cycles later `rsp_res`=1, `rsp_cout`=1, `rsp_id`=0.
- req1 SUB a=3 b=5: `rsp_res`=0xE, `rsp_cout`=0. Then SUB a=5 b=3: `rsp_res`=2, `rsp_cout`=1.
- Both requesters valid continuously after reset: grants alternate 0,1,0,1. The `rsp_id` sequence matches and no requester is starved.
- `rsp_ready` held low 5 cycles in RESP: `rsp_*` stable, both `reqN_ready` low, `busy`=1. Raising `rsp_ready` returns the FSM to IDLE the next cycle.
- `rst_n` pulsed low during EXEC: `rsp_valid` stays 0, `busy`=0 immediately, and the next request is served normally with requester 0 winning the tie.
- With `ALU_ARB_STATS_EN`: 3 grants to req0 and 2 to req1 give `grant_cnt0`=3 and `grant_cnt1`=2. Without the macro both read 0.
